// File: rtl/sram_pm_pkg.sv
// Shared types and constants for the power-managed 1R1W SRAM model.
package sram_pm_pkg;

  // Power-management states.
  typedef enum logic [1:0] {
    StActive,
    StSleep,
    StOff,
    StWake
  } pwr_state_e;

  // Poison pattern; the POISON parameter replicates it across the word width.
  localparam logic [31:0] POISON_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_1r1w_pm_if.sv
// Access and power-control bundle between a memory client (master) and the SRAM (slave).
interface sram_1r1w_pm_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 9
);

  logic                  deepsleep_i;
  logic                  powergate_i;
  logic                  ready_o;
  logic                  re_i;
  logic [ADDR_W-1:0]     raddr_i;
  logic [DATA_W-1:0]     rdata_o;
  logic                  rvalid_o;
  logic                  we_i;
  logic [ADDR_W-1:0]     waddr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [DATA_W/8-1:0]   be_i;
  logic                  err_o;

  modport master (
    output deepsleep_i, powergate_i, re_i, raddr_i, we_i, waddr_i, wdata_i, be_i,
    input  ready_o, rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  deepsleep_i, powergate_i, re_i, raddr_i, we_i, waddr_i, wdata_i, be_i,
    output ready_o, rdata_o, rvalid_o, err_o
  );

endinterface

// File: rtl/sram_pm_fsm.sv
// Power-management FSM: state register, wake counter, registered ready and valid-clear strobe.
module sram_pm_fsm
  import sram_pm_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic deepsleep_i,
  input  logic powergate_i,
  output logic ready_o,
  output logic clr_valid_o
);

  localparam int unsigned CntW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] WakeLoad = CntW'(WAKE_CYCLES);

  pwr_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            ready_q;
  logic            clr_q;

  // State transitions; ready/clear are registered from the state being entered so they
  // line up with the state itself (ready only in ACTIVE, clear every cycle spent in OFF).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StWake;
      cnt_q   <= WakeLoad;
      ready_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      clr_q   <= 1'b0;
      unique case (state_q)
        StActive: begin
          if (powergate_i) begin
            state_q <= StOff;
            clr_q   <= 1'b1;
          end else if (deepsleep_i) begin
            state_q <= StSleep;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StSleep: begin
          if (powergate_i) begin
            state_q <= StOff;
            clr_q   <= 1'b1;
          end else if (!deepsleep_i) begin
            if (WAKE_CYCLES == 0) begin
              state_q <= StActive;
              ready_q <= 1'b1;
            end else begin
              state_q <= StWake;
              cnt_q   <= WakeLoad;
            end
          end
        end
        StOff: begin
          if (powergate_i) begin
            clr_q <= 1'b1;
          end else if (deepsleep_i) begin
            state_q <= StSleep;
          end else begin
            state_q <= StWake;
            cnt_q   <= WakeLoad;
          end
        end
        StWake: begin
          if (powergate_i) begin
            state_q <= StOff;
            clr_q   <= 1'b1;
          end else if (deepsleep_i) begin
            state_q <= StSleep;
          end else if ((cnt_q == '0) || (cnt_q == CntW'(1))) begin
            // Last counted cycle in WAKE (or no wake delay at all).
            state_q <= StActive;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign clr_valid_o = clr_q;

endmodule

// File: rtl/sram_1r1w_pm.sv
// Single-clock 1R1W SRAM model with byte enables, RD_LAT pipeline, read-during-write policy,
// per-word valid tracking (poison on lost contents) and power management.
module sram_1r1w_pm
  import sram_pm_pkg::*;
#(
  parameter int unsigned     DATA_W      = 64,
  parameter int unsigned     DEPTH       = 512,
  parameter int unsigned     ADDR_W      = $clog2(DEPTH),
  parameter int unsigned     RD_LAT      = 1,
  parameter int unsigned     RDW_MODE    = 0,
  parameter int unsigned     WAKE_CYCLES = 4,
  parameter logic [DATA_W-1:0] POISON    = {DATA_W/32{POISON_WORD}}
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  sram_1r1w_pm_if.slave  bus
);

  localparam int unsigned NumBytes = DATA_W / 8;

  logic              ready;
  logic              clr_valid;
  logic              raddr_ok;
  logic              waddr_ok;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_ok;
  logic              err_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  sram_pm_fsm #(
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .deepsleep_i (bus.deepsleep_i),
    .powergate_i (bus.powergate_i),
    .ready_o     (ready),
    .clr_valid_o (clr_valid)
  );

  // Address range checks only matter when DEPTH leaves part of the address space unmapped.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign raddr_ok = 1'b1;
    assign waddr_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
    assign raddr_ok = {1'b0, bus.raddr_i} < DepthLim;
    assign waddr_ok = {1'b0, bus.waddr_i} < DepthLim;
  end

  assign rd_acc = bus.re_i & ready;
  assign wr_acc = bus.we_i & ready;
  assign wr_ok  = wr_acc & waddr_ok;

  // Old read word, byte-merged write word and read-during-write selection.
  always_comb begin
    rd_old = POISON;
    if (raddr_ok && valid_q[bus.raddr_i]) begin
      rd_old = mem_q[bus.raddr_i];
    end
    // Unwritten bytes of an invalid word take the poison byte.
    wr_merged = POISON;
    if (waddr_ok && valid_q[bus.waddr_i]) begin
      wr_merged = mem_q[bus.waddr_i];
    end
    for (int unsigned k = 0; k < NumBytes; k++) begin
      if (bus.be_i[k]) begin
        wr_merged[8*k +: 8] = bus.wdata_i[8*k +: 8];
      end
    end
    rd_word = rd_old;
    // Same address: the merged write word is exactly the old word with enabled bytes replaced.
    if ((RDW_MODE == 1) && wr_ok && (bus.raddr_i == bus.waddr_i)) begin
      rd_word = wr_merged;
    end
  end

  // Storage array; not reset, lost contents are tracked by the valid bits.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[bus.waddr_i] <= wr_merged;
    end
  end

  // Per-word valid bits: cleared by reset and every cycle in OFF, set by any accepted write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_valid) begin
      valid_q <= '0;
    end else if (wr_ok) begin
      valid_q[bus.waddr_i] <= 1'b1;
    end
  end

  // Error pulse for accesses while not ready or to unmapped addresses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ((bus.re_i | bus.we_i) & ~ready) | (rd_acc & ~raddr_ok) | (wr_acc & ~waddr_ok);
    end
  end

  // Read pipeline runs independently of the power state so accepted reads always complete.
  if (RD_LAT == 2) begin : g_lat2
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    // Two-stage read pipeline; rdata holds while no read completes.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        rvalid_q   <= 1'b0;
        rdata_q    <= '0;
      end else begin
        s1_valid_q <= rd_acc;
        if (rd_acc) begin
          s1_data_q <= rd_word;
        end
        rvalid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rdata_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    // Single-stage read; rdata holds while no read completes.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) begin
          rdata_q <= rd_word;
        end
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.err_o    = err_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_sram_1r1w_pm.sv
// Bench for sram_1r1w_pm: two instances (512/RD_LAT=1/old-data and 500/RD_LAT=2/new-data)
// share one random+directed stimulus stream and are checked against a behavioural model.
module tb_sram_1r1w_pm;

  localparam int          WC   = 4;
  localparam logic [63:0] POIS = 64'hDEADBEEF_DEADBEEF;
  localparam int          M_ACT = 0;
  localparam int          M_SLP = 1;
  localparam int          M_OFF = 2;
  localparam int          M_WAK = 3;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ds, pg, re, we;
  logic [8:0]  raddr, waddr;
  logic [63:0] wdata;
  logic [7:0]  be;

  always #5 clk = ~clk;

  sram_1r1w_pm_if #(.DATA_W(64), .ADDR_W(9)) if0 ();
  sram_1r1w_pm_if #(.DATA_W(64), .ADDR_W(9)) if1 ();

  assign if0.deepsleep_i = ds;
  assign if0.powergate_i = pg;
  assign if0.re_i        = re;
  assign if0.raddr_i     = raddr;
  assign if0.we_i        = we;
  assign if0.waddr_i     = waddr;
  assign if0.wdata_i     = wdata;
  assign if0.be_i        = be;
  assign if1.deepsleep_i = ds;
  assign if1.powergate_i = pg;
  assign if1.re_i        = re;
  assign if1.raddr_i     = raddr;
  assign if1.we_i        = we;
  assign if1.waddr_i     = waddr;
  assign if1.wdata_i     = wdata;
  assign if1.be_i        = be;

  sram_1r1w_pm #(
    .DATA_W(64), .DEPTH(512), .RD_LAT(1), .RDW_MODE(0), .WAKE_CYCLES(WC)
  ) dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if0)
  );

  sram_1r1w_pm #(
    .DATA_W(64), .DEPTH(500), .RD_LAT(2), .RDW_MODE(1), .WAKE_CYCLES(WC)
  ) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if1)
  );

  logic        rv  [2];
  logic        rdy [2];
  logic        er  [2];
  logic [63:0] rd  [2];
  assign rv[0] = if0.rvalid_o;
  assign rv[1] = if1.rvalid_o;
  assign rdy[0] = if0.ready_o;
  assign rdy[1] = if1.ready_o;
  assign er[0] = if0.err_o;
  assign er[1] = if1.err_o;
  assign rd[0] = if0.rdata_o;
  assign rd[1] = if1.rdata_o;

  // Reference model state.
  logic [63:0] mem_m   [2][512];
  bit          val_m   [2][512];
  int          mst     [2];
  int          left    [2];
  bit          err_e   [2];
  logic [63:0] last_rd [2];
  exp_t        sbq     [2][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int dep(int i);
    return (i == 0) ? 512 : 500;
  endfunction

  function automatic int lat(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [63:0] merge(logic [63:0] base, logic [63:0] d, logic [7:0] b);
    logic [63:0] r;
    r = base;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  // One clock edge of the reference behaviour for instance i.
  task automatic model_step(int i);
    logic [63:0] old;
    bit          on;
    exp_t        e;
    if (!rst_n) begin
      mst[i]     = M_WAK;
      left[i]    = WC;
      err_e[i]   = 0;
      last_rd[i] = '0;
      for (int a = 0; a < 512; a++) val_m[i][a] = 0;
      sbq[i].delete();
      return;
    end
    on = (mst[i] == M_ACT);
    err_e[i] = ((re || we) && !on) || (on && re && int'(raddr) >= dep(i)) ||
               (on && we && int'(waddr) >= dep(i));
    if (on && re) begin
      old = POIS;
      if (int'(raddr) < dep(i) && val_m[i][raddr]) old = mem_m[i][raddr];
      if (i == 1 && we && waddr == raddr && int'(raddr) < dep(i)) old = merge(old, wdata, be);
      e.d   = old;
      e.due = cyc + lat(i) - 1;
      sbq[i].push_back(e);
    end
    if (on && we && int'(waddr) < dep(i)) begin
      mem_m[i][waddr] = merge(val_m[i][waddr] ? mem_m[i][waddr] : POIS, wdata, be);
      val_m[i][waddr] = 1;
    end
    if (mst[i] == M_OFF) begin
      for (int a = 0; a < 512; a++) val_m[i][a] = 0;
    end
    case (mst[i])
      M_ACT: begin
        if (pg) mst[i] = M_OFF;
        else if (ds) mst[i] = M_SLP;
      end
      M_SLP: begin
        if (pg) mst[i] = M_OFF;
        else if (!ds) begin
          mst[i]  = (WC == 0) ? M_ACT : M_WAK;
          left[i] = WC;
        end
      end
      M_OFF: begin
        if (!pg) begin
          mst[i]  = ds ? M_SLP : M_WAK;
          left[i] = WC;
        end
      end
      default: begin
        if (pg) mst[i] = M_OFF;
        else if (ds) mst[i] = M_SLP;
        else begin
          left[i] = left[i] - 1;
          if (left[i] <= 0) mst[i] = M_ACT;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
  end

  // Monitor: compares DUT outputs to the model away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk("ready", i, 64'(rdy[i]), 64'(mst[i] == M_ACT));
        chk("err", i, 64'(er[i]), 64'(err_e[i]));
        if (rv[i]) begin
          if (sbq[i].size() == 0) begin
            chk("spurious_rvalid", i, 64'(rv[i]), 64'd0);
          end else begin
            e = sbq[i].pop_front();
            chk("rvalid_latency", i, 64'(cyc), 64'(e.due));
            chk("rdata", i, rd[i], e.d);
            last_rd[i] = e.d;
          end
        end else begin
          if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
            e = sbq[i].pop_front();
            chk("missing_rvalid", i, 64'(rv[i]), 64'd1);
          end
          chk("rdata_hold", i, rd[i], last_rd[i]);
        end
      end
    end
  end

  task automatic idle(int n);
    re = 0;
    we = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(int a, logic [63:0] d, logic [7:0] b);
    we = 1; waddr = 9'(a); wdata = d; be = b;
    @(negedge clk);
    we = 0;
  endtask

  task automatic do_read(int a);
    re = 1; raddr = 9'(a);
    @(negedge clk);
    re = 0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 60 && !if0.ready_o; n++) @(negedge clk);
    chk("wait_ready", 0, 64'(if0.ready_o), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout cyc %0d: got no finish expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pw_len;
    bit pw_gate;
    rst_n = 0; ds = 0; pg = 0; re = 0; we = 0;
    raddr = '0; waddr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);

    // Wake-up length after reset, plus a read while not ready.
    rst_n = 1; re = 1; raddr = 9'd1;
    @(negedge clk);
    re = 0;
    n = 1;
    chk("err_not_ready", 0, 64'(if0.err_o), 64'd1);
    chk("no_rvalid_not_ready", 0, 64'(if0.rvalid_o), 64'd0);
    while (!if0.ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wake_len", 0, 64'(n), 64'(WC));

    // Byte-enable read-modify-write.
    do_write(5, 64'h0123456789ABCDEF, 8'hFF);
    do_write(5, 64'h00000000000000FF, 8'h01);
    do_read(5);
    idle(3);
    chk("be_merge", 0, if0.rdata_o, 64'h0123456789ABCDFF);
    chk("be_merge", 1, if1.rdata_o, 64'h0123456789ABCDFF);

    // Read during write, same address.
    do_write(7, 64'h2222222222222222, 8'hFF);
    we = 1; waddr = 9'd7; wdata = 64'h1111111111111111; be = 8'hFF;
    re = 1; raddr = 9'd7;
    @(negedge clk);
    idle(3);
    chk("rdw_old", 0, if0.rdata_o, 64'h2222222222222222);
    chk("rdw_new", 1, if1.rdata_o, 64'h1111111111111111);

    // Retention through deep sleep.
    do_write(3, 64'hA5A5A5A5_5A5A5A5A, 8'hFF);
    ds = 1;
    repeat (10) @(negedge clk);
    chk("sleep_not_ready", 0, 64'(if0.ready_o), 64'd0);
    ds = 0;
    wait_ready();
    do_read(3);
    idle(3);
    chk("retain", 0, if0.rdata_o, 64'hA5A5A5A5_5A5A5A5A);
    chk("retain", 1, if1.rdata_o, 64'hA5A5A5A5_5A5A5A5A);

    // Content loss through power gate, then partial write over poison.
    pg = 1;
    repeat (3) @(negedge clk);
    pg = 0;
    wait_ready();
    do_read(3);
    idle(3);
    chk("poison", 0, if0.rdata_o, POIS);
    do_write(3, 64'h0011223344556677, 8'h0F);
    do_read(3);
    idle(3);
    chk("poison_merge", 0, if0.rdata_o, 64'hDEADBEEF_44556677);
    chk("poison_merge", 1, if1.rdata_o, 64'hDEADBEEF_44556677);

    // Accepted reads complete after leaving ACTIVE (sleep, then power gate).
    do_write(9, 64'hCAFEF00D_12345678, 8'hFF);
    re = 1; raddr = 9'd9;
    @(negedge clk);
    re = 0; ds = 1;
    repeat (3) @(negedge clk);
    chk("read_across_sleep", 1, if1.rdata_o, 64'hCAFEF00D_12345678);
    ds = 0;
    wait_ready();
    do_write(9, 64'h0BADC0DE_87654321, 8'hFF);
    re = 1; raddr = 9'd9;
    @(negedge clk);
    re = 0; pg = 1;
    repeat (3) @(negedge clk);
    chk("read_across_off", 1, if1.rdata_o, 64'h0BADC0DE_87654321);
    pg = 0;
    wait_ready();

    // Reset mid-read flushes the pipeline.
    do_write(9, 64'h5555AAAA_5555AAAA, 8'hFF);
    re = 1; raddr = 9'd9;
    @(negedge clk);
    re = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_flush_rvalid", 1, 64'(if1.rvalid_o), 64'd0);
    chk("reset_flush_rdata", 1, if1.rdata_o, 64'd0);
    rst_n = 1;
    wait_ready();

    // Unmapped address on the 500-word instance.
    do_write(505, 64'h7777777777777777, 8'hFF);
    do_read(505);
    idle(3);
    chk("oor_read", 1, if1.rdata_o, POIS);
    chk("inrange_505", 0, if0.rdata_o, 64'h7777777777777777);

    // Random traffic with occasional power events.
    pw_len = 0;
    pw_gate = 0;
    for (int c = 0; c < 500; c++) begin
      re    = $urandom_range(0, 1) == 1;
      we    = $urandom_range(0, 1) == 1;
      raddr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(490, 511)) : 9'($urandom_range(0, 15));
      waddr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(490, 511)) : 9'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      be    = 8'($urandom_range(0, 255));
      if (pw_len == 0 && $urandom_range(0, 59) == 0) begin
        pw_len  = $urandom_range(1, 6);
        pw_gate = $urandom_range(0, 2) == 0;
      end
      if (pw_len > 0) begin
        pw_len--;
        ds = !pw_gate;
        pg = pw_gate;
      end else begin
        ds = 0;
        pg = 0;
      end
      @(negedge clk);
    end
    ds = 0; pg = 0;
    idle(1);
    wait_ready();
    idle(5);
    chk("drain", 0, 64'(sbq[0].size()), 64'd0);
    chk("drain", 1, 64'(sbq[1].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_pm.md
Name: sram_1r1w_pm

Overview:
- Parametrised single-clock, one-read/one-write SRAM simulation model; successor to the fixed 512x64 dual-clock model.
- Adds configurable geometry, per-byte write enables, selectable read latency and a read-during-write policy.
- Adds a power-management FSM (deep sleep with retention, power gate with content loss, timed wake-up), with ready and error signalling.
- Used by L2/private memory banks in simulation builds.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- DEPTH, 512, number of words.
- ADDR_W, $clog2(DEPTH), address width.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read+write in one cycle: 0 returns old data, 1 returns new merged data.
- WAKE_CYCLES, 4, cycles spent in WAKE before ACTIVE; 0 is legal.
- POISON, {DATA_W/32{32'hDEAD_BEEF}}, value returned for words whose contents were lost.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- deepsleep_i  in  1  request retention sleep
- powergate_i  in  1  request power-off; contents lost
- ready_o  out  1  1 only in ACTIVE state
- re_i  in  1  read request
- raddr_i  in  ADDR_W  read address
- rdata_o  out  DATA_W  read data
- rvalid_o  out  1  rdata_o valid pulse
- we_i  in  1  write request
- waddr_i  in  ADDR_W  write address
- wdata_i  in  DATA_W  write data
- be_i  in  DATA_W/8  per-byte write enable
- err_o  out  1  pulse: access attempted while not ready

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state=WAKE, wake counter=WAKE_CYCLES, all per-word valid bits cleared, read pipeline flushed. rdata_o=0, rvalid_o=0, err_o=0, ready_o=0.
- FSM states: ACTIVE, SLEEP, OFF, WAKE. powergate_i has priority over deepsleep_i.
  - ACTIVE: powergate_i -> OFF; else deepsleep_i -> SLEEP.
  - SLEEP: powergate_i -> OFF; else !deepsleep_i -> WAKE, counter loaded with WAKE_CYCLES; if WAKE_CYCLES=0, go directly to ACTIVE.
  - OFF: every cycle in OFF clears all valid bits. !powergate_i -> SLEEP if deepsleep_i, else WAKE (counter loaded).
  - WAKE: powergate_i -> OFF; else deepsleep_i -> SLEEP; else decrement counter each cycle and enter ACTIVE after exactly WAKE_CYCLES cycles in WAKE.
- Access acceptance: re_i/we_i are accepted only when ready_o=1 in that cycle. Otherwise no storage change and no rvalid_o; err_o=1 the following cycle for one cycle per offending cycle.
- Write: for each byte k with be_i[k]=1, storage[waddr_i] byte k <= wdata_i byte k; the word's valid bit is set. Bytes not written in a previously invalid word read as the matching POISON byte. be_i=0 with we_i=1 is a no-op that still sets valid.
- Read: rvalid_o=1 exactly RD_LAT cycles after the accepting edge. rdata_o = storage word, or POISON if the word's valid bit is clear. rdata_o holds its last value while rvalid_o=0.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: pre-write word.
  - RDW_MODE=1: pre-write word with enabled bytes replaced by wdata_i.
  - Different addresses are fully independent.
- Leaving ACTIVE mid-read: reads already accepted complete with normal latency and data, including RD_LAT=2 and a transition to OFF.
- Reset mid-read: the pipeline is flushed and no rvalid_o is produced.
- Address >= DEPTH (non-power-of-2 DEPTH): write is ignored, read returns POISON, err_o pulses.
- Contents are retained through SLEEP and WAKE. Contents are lost through OFF and through reset.

Decomposition:
- Package sram_pm_pkg: pwr_state_e enum (ACTIVE, SLEEP, OFF, WAKE) and the default POISON constant.
- Sub-module sram_pm_fsm: state register, wake counter, ready_o and the valid-clear strobe.
- Top level holds the storage array, the valid bit array, the byte merge, RDW selection and the RD_LAT pipeline.

Test Plan:
- Reset release with WAKE_CYCLES=4 -> ready_o rises exactly 4 cycles after the first edge with rst_ni=1. A read issued while ready_o=0 -> err_o=1 one cycle later, no rvalid_o.
- Write 0x0123456789ABCDEF to addr 5 (be=FF), then write be=0x01 data 0xFF to addr 5, then read addr 5 -> 0x0123456789ABCDFF. rvalid_o after 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2).
- Same-cycle write addr 7 = 0x11..11 (old contents 0x22..22) with read addr 7 -> RDW_MODE=0 returns 0x22..22; RDW_MODE=1 returns 0x11..11.
- Write addr 3, then deepsleep_i high for 10 cycles, then low -> ready_o returns after WAKE_CYCLES; read addr 3 returns the written value.
- Write addr 3, powergate_i pulse of 3 cycles -> ready_o low; after wake, read addr 3 returns POISON. A be=0x0F write then read returns the low 4 bytes written and the high 4 bytes from POISON.
- RD_LAT=2: read accepted, deepsleep_i asserted the next cycle -> rvalid_o still pulses with correct data. Reset asserted in the same scenario -> no rvalid_o.
